// File: rtl/gray_counter.sv
// Up/down counter held in binary, presented in binary and Gray code.
// Accepts a Gray-coded preload and flags boundary crossings (wrap) or blocked steps (sat).
module gray_counter #(
  parameter int unsigned WIDTH = 4,
  parameter bit          WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             wrap,
  output logic             sat
);

  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_wrap;
  logic             r_sat;

  logic [WIDTH-1:0] w_load_bin;
  logic [WIDTH-1:0] w_step_bin;
  logic [WIDTH-1:0] w_step_gray;
  logic             w_at_bound;
  logic             w_blocked;

  // Gray decode: binary bit i is the XOR of all Gray bits from i upward.
  always_comb begin
    w_load_bin = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_load_bin[i] = ^(load_gray >> i);
    end
  end

  // One step in the requested direction, and whether it crosses the boundary.
  always_comb begin
    w_step_bin  = up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
    w_step_gray = w_step_bin ^ (w_step_bin >> 1);
    w_at_bound  = up ? (r_bin == '1) : (r_bin == '0);
    w_blocked   = !WRAP && w_at_bound;
  end

  // Priority: rst > load > en > hold; pulses clear on every non-step cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else if (load) begin
      r_bin  <= w_load_bin;
      r_gray <= load_gray;
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end else if (en) begin
      if (w_blocked) begin
        r_wrap <= 1'b0;
        r_sat  <= 1'b1;
      end else begin
        r_bin  <= w_step_bin;
        r_gray <= w_step_gray;
        r_wrap <= WRAP && w_at_bound;
        r_sat  <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
      r_sat  <= 1'b0;
    end
  end

  assign count_bin  = r_bin;
  assign count_gray = r_gray;
  assign wrap       = r_wrap;
  assign sat        = r_sat;

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// driven by directed steps followed by a random phase, checked against a behavioural model.
module tb_gray_counter;

  typedef struct {
    logic [31:0] bin;
    logic [31:0] gray;
    logic        wrap;
    logic        sat;
    logic [1:0]  kind;   // 0 none, 1 unblocked step, 2 blocked step
  } exp_t;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_en, a_up, a_load;
  logic [3:0] a_lg, a_bin, a_gray;
  logic       a_wrap, a_sat;
  logic       b_rst, b_en, b_up, b_load;
  logic [3:0] b_lg, b_bin, b_gray;
  logic       b_wrap, b_sat;
  logic       c_rst, c_en, c_up, c_load;
  logic [7:0] c_lg, c_bin, c_gray;
  logic       c_wrap, c_sat;

  gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .load(a_load), .load_gray(a_lg),
    .count_bin(a_bin), .count_gray(a_gray), .wrap(a_wrap), .sat(a_sat));
  gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .load(b_load), .load_gray(b_lg),
    .count_bin(b_bin), .count_gray(b_gray), .wrap(b_wrap), .sat(b_sat));
  gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load), .load_gray(c_lg),
    .count_bin(c_bin), .count_gray(c_gray), .wrap(c_wrap), .sat(c_sat));

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned ma = 0, mb = 0, mc = 0;
  logic [31:0] pa = '0, pb = '0, pc = '0;
  exp_t qa[$], qb[$], qc[$];

  function automatic exp_t model(input int unsigned st, input logic r, e, u, l,
                                 input int unsigned lg, input int unsigned w, input bit wm);
    exp_t        x;
    int unsigned mask, b, bi;
    bit          bound;
    mask = 32'((64'd1 << w) - 64'd1);
    x = '{bin: '0, gray: '0, wrap: 1'b0, sat: 1'b0, kind: 2'd0};
    if (r) begin
      x.bin = '0;
    end else if (l) begin
      b = 0;
      for (int i = int'(w) - 1; i >= 0; i--) begin
        bi = ((lg >> i) & 32'd1) ^ ((i == int'(w) - 1) ? 32'd0 : ((b >> (i + 1)) & 32'd1));
        b  = b | (bi << i);
      end
      x.bin = b;
    end else if (e) begin
      bound = u ? (st == mask) : (st == 0);
      if (!wm && bound) begin
        x.bin  = st;
        x.sat  = 1'b1;
        x.kind = 2'd2;
      end else begin
        x.bin  = u ? ((st + 1) & mask) : ((st - 1) & mask);
        x.wrap = wm && bound;
        x.kind = 2'd1;
      end
    end else begin
      x.bin = st;
    end
    x.gray = (!r && l) ? lg : (x.bin ^ (x.bin >> 1));
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string n, input exp_t x, input logic [31:0] bin, input logic [31:0] gray,
                     input logic wr, input logic sa, input logic [31:0] prev);
    chk({n, "_bin"},  bin, x.bin);
    chk({n, "_gray"}, gray, x.gray);
    chk({n, "_wrap"}, 32'(wr), 32'(x.wrap));
    chk({n, "_sat"},  32'(sa), 32'(x.sat));
    if (x.kind == 2'd1) chk({n, "_flip1"}, 32'($countones(gray ^ prev)), 32'd1);
    else if (x.kind == 2'd2) chk({n, "_flip0"}, 32'($countones(gray ^ prev)), 32'd0);
  endtask

  // Push expectations for the inputs now applied, clock once, then pop and compare.
  task automatic cycle();
    exp_t x;
    qa.push_back(model(ma, a_rst, a_en, a_up, a_load, 32'(a_lg), 4, 1'b1)); ma = qa[$].bin;
    qb.push_back(model(mb, b_rst, b_en, b_up, b_load, 32'(b_lg), 4, 1'b0)); mb = qb[$].bin;
    qc.push_back(model(mc, c_rst, c_en, c_up, c_load, 32'(c_lg), 8, 1'b1)); mc = qc[$].bin;
    @(posedge clk);
    #1;
    x = qa.pop_front(); cmp("a", x, 32'(a_bin), 32'(a_gray), a_wrap, a_sat, pa); pa = 32'(a_gray);
    x = qb.pop_front(); cmp("b", x, 32'(b_bin), 32'(b_gray), b_wrap, b_sat, pb); pb = 32'(b_gray);
    x = qc.pop_front(); cmp("c", x, 32'(c_bin), 32'(c_gray), c_wrap, c_sat, pc); pc = 32'(c_gray);
  endtask

  task automatic idle_all();
    a_rst = 0; a_en = 0; a_up = 0; a_load = 0; a_lg = '0;
    b_rst = 0; b_en = 0; b_up = 0; b_load = 0; b_lg = '0;
    c_rst = 0; c_en = 0; c_up = 0; c_load = 0; c_lg = '0;
  endtask

  logic [3:0] seq [17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                           4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                           4'b0000};

  initial begin
    idle_all();
    a_rst = 1; b_rst = 1; c_rst = 1;
    cycle();
    chk("rst_a_gray", 32'(a_gray), 32'd0);
    chk("rst_a_bin",  32'(a_bin),  32'd0);

    // Full upward Gray cycle with the wrap pulse on 15 -> 0.
    idle_all();
    a_en = 1; a_up = 1;
    for (int k = 0; k < 16; k++) begin
      cycle();
      chk("seq_gray", 32'(a_gray), 32'(seq[k+1]));
      chk("seq_wrap", 32'(a_wrap), (k == 15) ? 32'd1 : 32'd0);
    end

    // Down from zero wraps to 15, next down gives 14.
    idle_all(); a_rst = 1; cycle();
    idle_all(); a_en = 1; a_up = 0; cycle();
    chk("dn_bin", 32'(a_bin), 32'd15);
    chk("dn_gray", 32'(a_gray), 32'b1000);
    chk("dn_wrap", 32'(a_wrap), 32'd1);
    cycle();
    chk("dn2_gray", 32'(a_gray), 32'b1001);
    chk("dn2_wrap", 32'(a_wrap), 32'd0);

    // Load takes priority over a simultaneous count.
    idle_all(); a_load = 1; a_lg = 4'b1110; a_en = 1; a_up = 1; cycle();
    chk("ld_bin", 32'(a_bin), 32'd11);
    chk("ld_gray", 32'(a_gray), 32'b1110);
    idle_all(); a_en = 1; a_up = 1; cycle();
    chk("ld_step_bin", 32'(a_bin), 32'd12);
    chk("ld_step_gray", 32'(a_gray), 32'b1010);

    // Saturating instance blocks at 15, then steps down.
    idle_all(); b_load = 1; b_lg = 4'b1000; cycle();
    chk("sat_ld_bin", 32'(b_bin), 32'd15);
    idle_all(); b_en = 1; b_up = 1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("sat_hold_bin", 32'(b_bin), 32'd15);
      chk("sat_hold_gray", 32'(b_gray), 32'b1000);
      chk("sat_pulse", 32'(b_sat), 32'd1);
      chk("sat_wrap", 32'(b_wrap), 32'd0);
    end
    b_up = 0; cycle();
    chk("sat_dn_bin", 32'(b_bin), 32'd14);
    chk("sat_dn_pulse", 32'(b_sat), 32'd0);

    // Reset beats load and en while counting.
    idle_all(); a_load = 1; a_lg = 4'b1101; cycle();
    chk("mid_ld_bin", 32'(a_bin), 32'd9);
    idle_all(); a_rst = 1; a_load = 1; a_lg = 4'b0110; a_en = 1; a_up = 1; cycle();
    chk("mid_rst_bin", 32'(a_bin), 32'd0);
    chk("mid_rst_gray", 32'(a_gray), 32'd0);
    idle_all(); a_en = 1; a_up = 1; cycle();
    chk("mid_resume_bin", 32'(a_bin), 32'd1);

    // Random phase on all three instances.
    for (int n = 0; n < 5000; n++) begin
      a_rst = ($urandom_range(0, 199) == 0); a_en = ($urandom_range(0, 3) != 0);
      a_up = 1'($urandom); a_load = ($urandom_range(0, 15) == 0); a_lg = 4'($urandom);
      b_rst = ($urandom_range(0, 199) == 0); b_en = ($urandom_range(0, 3) != 0);
      b_up = 1'($urandom); b_load = ($urandom_range(0, 15) == 0); b_lg = 4'($urandom);
      c_rst = ($urandom_range(0, 199) == 0); c_en = ($urandom_range(0, 3) != 0);
      c_up = 1'($urandom); c_load = ($urandom_range(0, 15) == 0); c_lg = 8'($urandom);
      cycle();
      chk("c_gray_id", 32'(c_gray), 32'(c_bin ^ (c_bin >> 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
